// File: rtl/cov_mac_pe.sv
// Covariance processing element: forwards operands systolically and accumulates
// framed dot products with signed/unsigned modes, overflow handling and framing checks.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no vector open; only a first-marked product is accepted
// ACCUM | vector open; products are summed until a last-marked product
module cov_mac_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  first_in,
    input  logic                  last_in,
    input  logic                  signed_mode,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  out_valid,
    output logic                  first_out,
    output logic                  last_out,
    output logic                  acc_valid,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  acc_ovf,
    output logic                  protocol_err
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int XW = ACC_WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // systolic forwarding
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            out_valid <= in_valid;
            first_out <= first_in;
            last_out  <= last_in;
        end
    end

    // stage 1: product
    logic          mode_q;
    logic          mode_eff;
    logic [PW-1:0] op_a;
    logic [PW-1:0] op_b;
    logic [PW-1:0] prod_d;

    logic          p_valid;
    logic          p_first;
    logic          p_last;
    logic          p_signed;
    logic [PW-1:0] prod;

    // a first-marked sample uses its own mode; later samples reuse the latched one
    assign mode_eff = first_in ? signed_mode : mode_q;

    always_comb begin
        op_a   = mode_eff ? {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in} : {{DATA_WIDTH{1'b0}}, a_in};
        op_b   = mode_eff ? {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in} : {{DATA_WIDTH{1'b0}}, b_in};
        prod_d = op_a * op_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            p_valid  <= 1'b0;
            p_first  <= 1'b0;
            p_last   <= 1'b0;
            p_signed <= 1'b0;
            prod     <= '0;
        end else begin
            p_valid <= in_valid;
            if (in_valid) begin
                prod     <= prod_d;
                p_first  <= first_in;
                p_last   <= last_in;
                p_signed <= mode_eff;
                if (first_in) begin
                    mode_q <= signed_mode;
                end
            end else begin
                p_first <= 1'b0;
                p_last  <= 1'b0;
            end
        end
    end

    // stage 2: accumulate
    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sticky_q, sticky_d;
    logic                 fin_pend_q, fin_pend_d;
    logic [ACC_WIDTH-1:0] fin_val_q, fin_val_d;
    logic                 fin_ovf_q, fin_ovf_d;
    logic                 err_q, err_d;

    logic [XW-1:0]        prod_x;
    logic [XW-1:0]        acc_x;
    logic [XW-1:0]        sum_x;
    logic                 ovf_step;
    logic [ACC_WIDTH-1:0] sat_val;
    logic [ACC_WIDTH-1:0] acc_step;

    always_comb begin
        prod_x = p_signed ? {{(XW - PW){prod[PW-1]}}, prod} : {{(XW - PW){1'b0}}, prod};
        acc_x  = p_signed ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
        sum_x  = acc_x + prod_x;
        if (p_signed) begin
            ovf_step = sum_x[XW-1] ^ sum_x[XW-2];
            sat_val  = sum_x[XW-1] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
        end else begin
            // unsigned sums can only overflow upward
            ovf_step = sum_x[XW-1];
            sat_val  = {ACC_WIDTH{1'b1}};
        end
        acc_step = (ovf_step && (SATURATE != 0)) ? sat_val : sum_x[ACC_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        fin_pend_d = 1'b0;
        fin_val_d  = fin_val_q;
        fin_ovf_d  = fin_ovf_q;
        err_d      = 1'b0;
        if (p_valid) begin
            if (p_first) begin
                // a first while a vector is open abandons the open vector
                err_d    = (state_q == ACCUM);
                acc_d    = prod_x[ACC_WIDTH-1:0];
                sticky_d = 1'b0;
                if (p_last) begin
                    fin_pend_d = 1'b1;
                    fin_val_d  = prod_x[ACC_WIDTH-1:0];
                    fin_ovf_d  = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = ACCUM;
                end
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                acc_d    = acc_step;
                sticky_d = sticky_q | ovf_step;
                if (p_last) begin
                    fin_pend_d = 1'b1;
                    fin_val_d  = acc_step;
                    fin_ovf_d  = sticky_q | ovf_step;
                    state_d    = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            fin_pend_q <= 1'b0;
            fin_val_q  <= '0;
            fin_ovf_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
            fin_pend_q <= fin_pend_d;
            fin_val_q  <= fin_val_d;
            fin_ovf_q  <= fin_ovf_d;
            err_q      <= err_d;
        end
    end

    // result/report registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid    <= 1'b0;
            acc_out      <= '0;
            acc_ovf      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            acc_valid    <= fin_pend_q;
            protocol_err <= err_q;
            if (fin_pend_q) begin
                acc_out <= fin_val_q;
                acc_ovf <= fin_ovf_q;
            end
        end
    end

endmodule
